// File: rtl/piso_serializer.sv
// piso_serializer: framed parallel-in/serial-out transmitter (start, data, stop).
// Define PISO_PARITY_EN to insert an even-parity bit between data and stop.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;
  logic             head;
  logic [WIDTH-1:0] sh_next;
  logic             last_bit;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
`endif

  // Head of the shift register is the next bit to put on the line.
  assign head     = LSB_FIRST ? sh_q[0] : sh_q[WIDTH-1];
  assign sh_next  = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    sout_d  = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rdy_d   = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
        if (load_valid && rdy_q) begin
          state_d = S_START;
          sh_d    = din;
          sout_d  = 1'b0;
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
`ifdef PISO_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
        sout_d  = head;
        sh_d    = sh_next;
        busy_d  = 1'b1;
      end
      S_DATA: begin
        busy_d = 1'b1;
        if (last_bit) begin
          cnt_d = '0;
`ifdef PISO_PARITY_EN
          state_d = S_PAR;
          sout_d  = par_q;
`else
          state_d = S_STOP;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d  = cnt_q + CW'(1);
          sout_d = head;
          sh_d   = sh_next;
        end
      end
`ifdef PISO_PARITY_EN
      S_PAR: begin
        state_d = S_STOP;
        busy_d  = 1'b1;
        done_d  = 1'b1;
      end
`endif
      S_STOP: begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        sh_d    = '0;
        cnt_d   = '0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  assign sout       = sout_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = rdy_q;

endmodule
